// File: rtl/scan_mux_dec_if.sv
// Channel-scan bus between the data sources / control and the scan mux.
// Ports: en, mode, sel_in, ch_mask, data_in (master drives);
//        data_out, ch_onehot, ch_idx, step (slave drives).
interface scan_mux_dec_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      en;
    logic                      mode;
    logic [SEL_W-1:0]          sel_in;
    logic [CHANNELS-1:0]       ch_mask;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [WIDTH-1:0]          data_out;
    logic [CHANNELS-1:0]       ch_onehot;
    logic [SEL_W-1:0]          ch_idx;
    logic                      step;

    modport master (
        output en,
        output mode,
        output sel_in,
        output ch_mask,
        output data_in,
        input  data_out,
        input  ch_onehot,
        input  ch_idx,
        input  step
    );

    modport slave (
        input  en,
        input  mode,
        input  sel_in,
        input  ch_mask,
        input  data_in,
        output data_out,
        output ch_onehot,
        output ch_idx,
        output step
    );
endinterface

// File: rtl/scan_mux_dec.sv
// N-channel time-multiplexed word selector with one-hot channel decode.
// Ports: clk, rst (async, active high), bus (scan_mux_dec_if.slave).
module scan_mux_dec #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DIV      = 3
) (
    input  logic          clk,
    input  logic          rst,
    scan_mux_dec_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);
    localparam logic [SEL_W:0] CH_N    = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0]    ch_idx_q, ch_idx_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [CHANNELS-1:0] onehot_q, onehot_d;
    logic                step_q, step_d;

    logic [CHANNELS-1:0][WIDTH-1:0] words;
    logic [WIDTH-1:0]    word;
    logic                sel_ok;
    logic                blank;

    logic [SEL_W:0]      sum;
    logic [SEL_W-1:0]    cand;
    logic [SEL_W-1:0]    nxt;
    logic                found;

    assign words = bus.data_in;
    assign word  = words[ch_idx_q];

    assign sel_ok = ({1'b0, bus.sel_in} < CH_N);

    // Blank when frozen, when the current auto channel is masked off,
    // or when the manual select points past the last channel.
    assign blank = !bus.en
                || (!bus.mode && !bus.ch_mask[ch_idx_q])
                || (bus.mode && !sel_ok);

    // Upward search with wrap for the next enabled channel. The last
    // candidate (k = CHANNELS) is the current channel itself, so a
    // lone enabled channel reloads itself. The sum is reduced modulo
    // CHANNELS so non-power-of-two counts never yield a bad index.
    always_comb begin
        nxt   = ch_idx_q;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            sum = {1'b0, ch_idx_q} + (SEL_W + 1)'(k);
            if (sum >= CH_N) begin
                sum = sum - CH_N;
            end
            cand = sum[SEL_W-1:0];
            if (!found && bus.ch_mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ch_idx_d = ch_idx_q;
        pre_d    = pre_q;
        step_d   = 1'b0;
        data_d   = blank ? '0 : word;
        onehot_d = blank ? '0 : (CHANNELS'(1) << ch_idx_q);

        if (!bus.en) begin
            ch_idx_d = ch_idx_q;
            pre_d    = pre_q;
        end else if (bus.mode) begin
            // Manual: dwell restarts so a return to auto gets a full one.
            pre_d = '0;
            if (sel_ok) begin
                ch_idx_d = bus.sel_in;
            end
        end else if (pre_q == PRE_MAX) begin
            // Dwell expiry; with no channel enabled the index holds.
            pre_d  = '0;
            step_d = 1'b1;
            if (found) begin
                ch_idx_d = nxt;
            end
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_idx_q <= '0;
            pre_q    <= '0;
            data_q   <= '0;
            onehot_q <= '0;
            step_q   <= 1'b0;
        end else begin
            ch_idx_q <= ch_idx_d;
            pre_q    <= pre_d;
            data_q   <= data_d;
            onehot_q <= onehot_d;
            step_q   <= step_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.ch_onehot = onehot_q;
    assign bus.ch_idx    = ch_idx_q;
    assign bus.step      = step_q;
endmodule

// File: doc/scan_mux_dec.md
Name: scan_mux_dec

Overview:
- Parametrised N-channel, W-bit time-multiplexed selector with a built-in channel decoder.
- In auto mode, an internal prescaled counter cycles through the enabled channels. It presents the selected word on a registered output and raises a one-hot strobe for the active channel.
- In manual mode, the channel follows an external select.
- Sits between per-channel data sources (e.g. per-digit display words) and a shared output path.

Parameters:
- CHANNELS, 4, number of input channels (>=2).
- WIDTH, 8, bits per channel word.
- DIV, 3, clock cycles each channel is held in auto mode (>=1).
- SEL_W, $clog2(CHANNELS), width of the channel index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  scan enable; low = freeze and blank.
- mode  input  1  0 = auto scan, 1 = manual select.
- sel_in  input  SEL_W  manual channel index.
- ch_mask  input  CHANNELS  auto-mode channel enable; bit i = 1 means channel i is included.
- data_in  input  CHANNELS*WIDTH  packed words; channel i = data_in[i*WIDTH +: WIDTH].
- data_out  output  WIDTH  registered selected word.
- ch_onehot  output  CHANNELS  registered decode of the active channel; bit i = 1 means channel i is active.
- ch_idx  output  SEL_W  current channel index (state register).
- step  output  1  one-cycle pulse on each auto-mode dwell expiry.

Behaviour:
- Reset (async, rst=1):
  - ch_idx=0, prescaler=0, data_out=0, ch_onehot=0, step=0.
  - All values hold while rst is high.
  - Reset mid-scan aborts the dwell immediately.
- Output registering:
  - Every cycle, data_out <= word[ch_idx] and ch_onehot <= (1<<ch_idx), both taken from the pre-edge ch_idx.
  - Latency is one cycle from a data_in change or an index change.
- Blanking: data_out <= 0 and ch_onehot <= 0 when any of the following holds:
  - en=0;
  - mode=0 and ch_mask[ch_idx]=0;
  - mode=1 and sel_in >= CHANNELS.
- en=0: prescaler and ch_idx hold; step=0.
- Auto mode (mode=0, en=1):
  - Prescaler counts 0..DIV-1.
  - At DIV-1 the prescaler wraps to 0 and step is 1 for that cycle.
  - On that same edge, ch_idx loads the next index after ch_idx, searching upward with wrap-around from CHANNELS-1 to 0, for which ch_mask is 1.
  - If ch_idx is the only unmasked channel, ch_idx reloads itself and step still pulses.
  - If ch_mask is all zeros, ch_idx holds, step still pulses, and outputs are blanked.
  - With DIV=1, ch_idx advances every cycle and step is constantly 1.
  - A mask change takes effect at the next advance; the current channel is blanked immediately if its mask bit is cleared.
- Manual mode (mode=1, en=1):
  - Prescaler is forced to 0; step=0; ch_mask is ignored.
  - ch_idx <= sel_in if sel_in < CHANNELS; otherwise ch_idx holds and outputs are blanked.
- Mode switch:
  - Manual to auto: scanning resumes from the current ch_idx with prescaler=0, so the first step occurs DIV cycles later.
  - Auto to manual: takes effect on the same edge.
- en and mode sampled on the same edge:
  - en=0 dominates mode.
  - rst dominates everything.
- Non-power-of-two CHANNELS: the search never yields an index >= CHANNELS.

Test Plan:
1. Reset then auto scan (CHANNELS=4, WIDTH=8, DIV=3; data_in={8'h44,8'h33,8'h22,8'h11}; ch_mask=4'b1111; en=1; mode=0):
   - ch_idx sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0.
   - step is high on cycles 3,6,9,12.
   - data_out follows one cycle behind: 11,22,33,44.
   - ch_onehot is 0001,0010,0100,1000.
2. Mask skip (ch_mask=4'b1010, start ch_idx=1):
   - ch_idx sequence is 1,3,1,3, each held 3 cycles.
   - ch_onehot alternates 0010/1000.
   - Channels 0 and 2 never appear.
3. All masked (ch_mask=0 mid-dwell on channel 2):
   - Next cycle data_out=0 and ch_onehot=0.
   - ch_idx stays 2.
   - step keeps pulsing every 3 cycles.
4. Manual mode:
   - mode=1, sel_in=2 gives ch_idx=2, then data_out=8'h33 and ch_onehot=0100 one cycle later; step=0.
   - sel_in=3 then gives data_out=8'h44.
   - Returning to mode=0 gives the first step 3 cycles later, advancing to 0.
5. en=0 for 5 cycles mid-dwell (prescaler=1, ch_idx=1):
   - Outputs are 0 during the freeze.
   - On re-enable, ch_idx=1 resumes and step fires 2 cycles later.
6. Async reset asserted between clock edges during ch_idx=3:
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release, scanning restarts at ch_idx=0 with the full 3-cycle dwell.
